// File: rtl/sqrt_dist_pkg.sv
// Shared types and helpers for the ordered square-root distributor.
package sqrt_dist_pkg;

  // Per-worker lifecycle: free, iterating, or holding a finished result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } worker_state_t;

  // Width of a pointer that indexes n workers (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sqrt_iter_worker.sv
// One iterative square-root worker: restoring digit-by-digit, one bit pair
// per cycle, starting from the highest nonzero pair of the argument.
module sqrt_iter_worker
  import sqrt_dist_pkg::*;
#(
  parameter int W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic [W-1:0]    arg,
  input  logic            free,
  output worker_state_t   state,
  output logic [W/2-1:0]  res
);

  localparam int RW  = W / 2;
  localparam int RMW = RW + 2;
  localparam int PW  = $clog2(RW);

  logic [W-1:0]     x_sh;
  logic [RMW-1:0]   rem;
  logic [RW-1:0]    root;
  logic [PW-1:0]    steps;

  logic [PW-1:0]    first_pair;
  logic [RMW+1:0]   cur;
  logic [RMW+1:0]   sub;
  logic [RMW+1:0]   diff;
  logic             ge;
  logic [RMW-1:0]   next_rem;
  logic [RW-1:0]    next_root;

  // Locate the highest nonzero bit pair; zero maps to pair 0 (one step).
  always_comb begin
    first_pair = '0;
    for (int i = 0; i < RW; i++) begin
      if (arg[2*i +: 2] != 2'b00) first_pair = PW'(i);
    end
  end

  // One restoring step: bring down the next pair, try to subtract 4*root+1.
  // The stored remainder never exceeds 2*root, so RMW bits always suffice.
  always_comb begin
    cur       = {rem, x_sh[W-1:W-2]};
    sub       = {2'b00, root, 2'b01};
    ge        = (cur >= sub);
    diff      = cur - sub;
    next_rem  = ge ? diff[RMW-1:0] : cur[RMW-1:0];
    next_root = {root[RW-2:0], ge};
  end

  // Worker FSM: load on accept, iterate until the last pair, hold until freed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x_sh  <= '0;
      rem   <= '0;
      root  <= '0;
      steps <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arg_vld) begin
            state <= CALC;
            x_sh  <= arg << (2 * (RW - 1 - int'(first_pair)));
            rem   <= '0;
            root  <= '0;
            steps <= first_pair;
          end
        end
        CALC: begin
          rem  <= next_rem;
          root <= next_root;
          x_sh <= x_sh << 2;
          if (steps == '0) state <= DONE;
          else             steps <= steps - 1'b1;
        end
        DONE: begin
          if (free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res = root;

endmodule

// File: rtl/sqrt_distributor_ordered.sv
// Round-robin distributor over N_WORKERS square-root workers with in-order
// result return.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends combinationally on valid on either port, and
// res_vld/res hold steady while res_rdy is 0.
module sqrt_distributor_ordered
  import sqrt_dist_pkg::*;
#(
  parameter int N_WORKERS = 4,
  parameter int W         = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             arg_vld,
  output logic                             arg_rdy,
  input  logic [W-1:0]                     arg,
  output logic                             res_vld,
  input  logic                             res_rdy,
  output logic [W/2-1:0]                   res,
  output logic [$clog2(N_WORKERS+1)-1:0]   busy_cnt
);

  localparam int PW = ptr_width(N_WORKERS);

  logic [PW-1:0]        issue_ptr;
  logic [PW-1:0]        read_ptr;
  logic                 in_xfer;
  logic                 out_xfer;
  logic [N_WORKERS-1:0] w_busy;
  logic [N_WORKERS-1:0] w_done;
  logic [N_WORKERS-1:0] w_start;
  logic [N_WORKERS-1:0] w_free;
  worker_state_t        w_state [N_WORKERS];
  logic [W/2-1:0]       w_res   [N_WORKERS];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(N_WORKERS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign arg_rdy  = ~w_busy[issue_ptr];
  assign res_vld  = w_done[read_ptr];
  assign res      = res_vld ? w_res[read_ptr] : '0;
  assign in_xfer  = arg_vld & arg_rdy;
  assign out_xfer = res_vld & res_rdy;

  for (genvar i = 0; i < N_WORKERS; i++) begin : g_worker
    assign w_busy[i]  = (w_state[i] != IDLE);
    assign w_done[i]  = (w_state[i] == DONE);
    assign w_start[i] = in_xfer  && (issue_ptr == PW'(i));
    assign w_free[i]  = out_xfer && (read_ptr  == PW'(i));

    sqrt_iter_worker #(.W(W)) u_worker (
      .clk     (clk),
      .rst     (rst),
      .arg_vld (w_start[i]),
      .arg     (arg),
      .free    (w_free[i]),
      .state   (w_state[i]),
      .res     (w_res[i])
    );
  end

  // Pointers advance on their own port's transfer; occupancy tracks the net change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_ptr <= '0;
      read_ptr  <= '0;
      busy_cnt  <= '0;
    end else begin
      if (in_xfer)  issue_ptr <= ptr_next(issue_ptr);
      if (out_xfer) read_ptr  <= ptr_next(read_ptr);
      case ({in_xfer, out_xfer})
        2'b10:   busy_cnt <= busy_cnt + 1'b1;
        2'b01:   busy_cnt <= busy_cnt - 1'b1;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

endmodule
